// File: rtl/pcs_rx_gearbox_lock_pkg.sv
// rtl/pcs_rx_gearbox_lock_pkg.sv - shared widths, sync headers and lock FSM states for the PCS RX gearbox
package pcs_rx_gearbox_lock_pkg;

    localparam int HEAD_W    = 2;
    localparam int DATA_W    = 64;
    localparam int BLOCK_W   = HEAD_W + DATA_W;
    localparam int LOCK_CNT  = 64;
    localparam int INVLD_MAX = 16;
    localparam int BUF_W     = 2 * BLOCK_W - 2;
    localparam int FILL_W    = 8;
    localparam int SH_CNT_W  = 7;
    localparam int INVLD_W   = 5;

    localparam logic [HEAD_W-1:0] SYNC_DATA = 2'b01;
    localparam logic [HEAD_W-1:0] SYNC_CTRL = 2'b10;

    typedef enum logic [2:0] {
        LOCK_INIT,
        RESET_CNT,
        TEST_SH,
        SLIP,
        SLIP_WAIT
    } lock_state_t;

    function automatic logic sync_valid(input logic [HEAD_W-1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/pcs_rx_gearbox.sv
// rtl/pcs_rx_gearbox.sv - 64->66 bit gearbox with single-bit slip and registered block output
module pcs_rx_gearbox
    import pcs_rx_gearbox_lock_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               data_v,
    input  logic [DATA_W-1:0]  data,
    input  logic               slip_req,
    output logic               slip_pend,
    output logic               nxt_v,
    output logic [HEAD_W-1:0]  nxt_hdr,
    output logic               block_v,
    output logic [BLOCK_W-1:0] block
);

    logic [BUF_W-1:0]   sbuf_q;
    logic [BUF_W-1:0]   merged;
    logic [FILL_W-1:0]  fill_q;
    logic [FILL_W-1:0]  nfill;
    logic               slip_pend_q;
    logic               block_v_q;
    logic [BLOCK_W-1:0] block_q;

    // Bits above fill are always zero, so a pending slip is a plain right shift of the merged word.
    always_comb begin
        merged  = (sbuf_q | ({{(BUF_W-DATA_W){1'b0}}, data} << fill_q)) >> slip_pend_q;
        nfill   = fill_q + FILL_W'(DATA_W) - FILL_W'(slip_pend_q);
        nxt_v   = data_v && (nfill >= FILL_W'(BLOCK_W));
        nxt_hdr = merged[HEAD_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sbuf_q      <= '0;
            fill_q      <= '0;
            slip_pend_q <= 1'b0;
            block_v_q   <= 1'b0;
            block_q     <= '0;
        end else begin
            slip_pend_q <= slip_req | (slip_pend_q & ~data_v);
            block_v_q   <= nxt_v;
            if (data_v) begin
                if (nxt_v) begin
                    sbuf_q  <= merged >> BLOCK_W;
                    fill_q  <= nfill - FILL_W'(BLOCK_W);
                    block_q <= merged[BLOCK_W-1:0];
                end else begin
                    sbuf_q <= merged;
                    fill_q <= nfill;
                end
            end
        end
    end

    assign slip_pend = slip_pend_q;
    assign block_v   = block_v_q;
    assign block     = block_q;

endmodule

// File: rtl/pcs_rx_gearbox_lock.sv
// rtl/pcs_rx_gearbox_lock.sv - RX gearbox plus block-lock FSM; PCS_RX_LOCK_STATS_EN adds slip/lock-loss counters
module pcs_rx_gearbox_lock
    import pcs_rx_gearbox_lock_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               data_v_i,
    input  logic [DATA_W-1:0]  data_i,
    output logic               block_v_o,
    output logic [BLOCK_W-1:0] block_o,
    output logic               block_lock_o,
    output logic               slip_o
`ifdef PCS_RX_LOCK_STATS_EN
    ,
    output logic [15:0]        slip_cnt_o,
    output logic [15:0]        lock_loss_cnt_o
`endif
);

    lock_state_t         state_q, state_n;
    logic                nxt_v, slip_pend, slip, cnt_clr;
    logic [HEAD_W-1:0]   nxt_hdr;
    logic                hdr_ok, test_en, cnt_hit, invld_hit, lock_set, lock_clr, lock_q;
    logic [SH_CNT_W-1:0] sh_cnt_q, sh_cnt_n;
    logic [INVLD_W-1:0]  sh_invld_q, sh_invld_n;

    pcs_rx_gearbox u_gearbox (
        .clk       (clk),
        .reset     (reset),
        .data_v    (data_v_i),
        .data      (data_i),
        .slip_req  (slip),
        .slip_pend (slip_pend),
        .nxt_v     (nxt_v),
        .nxt_hdr   (nxt_hdr),
        .block_v   (block_v_o),
        .block     (block_o)
    );

    always_comb begin
        hdr_ok     = sync_valid(nxt_hdr);
        test_en    = (state_q == TEST_SH) && nxt_v;
        sh_cnt_n   = (sh_cnt_q == '1) ? sh_cnt_q : sh_cnt_q + 1'b1;
        sh_invld_n = (!hdr_ok && sh_invld_q != '1) ? sh_invld_q + 1'b1 : sh_invld_q;
        cnt_hit    = (sh_cnt_n == SH_CNT_W'(LOCK_CNT));
        invld_hit  = !hdr_ok && (sh_invld_n == INVLD_W'(INVLD_MAX));
        lock_set   = test_en && !lock_q && hdr_ok && cnt_hit;
        lock_clr   = test_en && lock_q && invld_hit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= LOCK_INIT;
        else       state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            LOCK_INIT: state_n = RESET_CNT;
            RESET_CNT: if (!slip_pend) state_n = TEST_SH;
            TEST_SH: begin
                if (test_en) begin
                    if (lock_q ? invld_hit : !hdr_ok) state_n = SLIP;
                    else if (cnt_hit)                  state_n = RESET_CNT;
                end
            end
            SLIP:      state_n = SLIP_WAIT;
            // Hold until the gearbox has consumed the slip on a valid beat.
            SLIP_WAIT: if (!slip_pend) state_n = RESET_CNT;
            default:   state_n = LOCK_INIT;
        endcase
    end

    always_comb begin
        slip    = (state_q == SLIP);
        cnt_clr = (state_q == RESET_CNT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_cnt_q   <= '0;
            sh_invld_q <= '0;
            lock_q     <= 1'b0;
        end else begin
            if (cnt_clr) begin
                sh_cnt_q   <= '0;
                sh_invld_q <= '0;
            end else if (test_en) begin
                sh_cnt_q   <= sh_cnt_n;
                sh_invld_q <= sh_invld_n;
            end
            if (lock_set)      lock_q <= 1'b1;
            else if (lock_clr) lock_q <= 1'b0;
        end
    end

    assign block_lock_o = lock_q;
    assign slip_o       = slip;

`ifdef PCS_RX_LOCK_STATS_EN
    logic [15:0] slip_cnt_q, lock_loss_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slip_cnt_q  <= '0;
            lock_loss_q <= '0;
        end else begin
            if (slip && slip_cnt_q != '1)      slip_cnt_q  <= slip_cnt_q + 1'b1;
            if (lock_clr && lock_loss_q != '1) lock_loss_q <= lock_loss_q + 1'b1;
        end
    end

    assign slip_cnt_o      = slip_cnt_q;
    assign lock_loss_cnt_o = lock_loss_q;
`endif

endmodule

// File: tb/tb_pcs_rx_gearbox_lock.sv
// tb/tb_pcs_rx_gearbox_lock.sv - scoreboard bench for pcs_rx_gearbox_lock (optionally with PCS_RX_LOCK_STATS_EN)
module tb_pcs_rx_gearbox_lock;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        data_v_i = 1'b0;
    logic [63:0] data_i = '0;
    logic        block_v_o;
    logic [65:0] block_o;
    logic        block_lock_o;
    logic        slip_o;
`ifdef PCS_RX_LOCK_STATS_EN
    logic [15:0] slip_cnt_o;
    logic [15:0] lock_loss_cnt_o;
`endif

    always #5 clk = ~clk;

    pcs_rx_gearbox_lock dut (
        .clk          (clk),
        .reset        (reset),
        .data_v_i     (data_v_i),
        .data_i       (data_i),
        .block_v_o    (block_v_o),
        .block_o      (block_o),
        .block_lock_o (block_lock_o),
        .slip_o       (slip_o)
`ifdef PCS_RX_LOCK_STATS_EN
        ,
        .slip_cnt_o      (slip_cnt_o),
        .lock_loss_cnt_o (lock_loss_cnt_o)
`endif
    );

    typedef struct packed {
        logic [65:0] blk;
        logic        lock;
    } exp_t;

    localparam logic [65:0] CONST_BLK = {64'hFFFF_FFFF_FFFF_FFFF, 2'b01};
    localparam logic [65:0] BAD_BLK   = {64'hFFFF_FFFF_FFFF_FFFF, 2'b00};

    exp_t exp_q[$];
    exp_t pend_q[$];
    bit   bitq[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   slips = 0;
    int   blk_seen = 0;
    int   mon_mode = 0;
    int   bits_sent = 0;
    int   blocks_moved = 0;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: mode 0 pops the scoreboard, mode 1 expects the constant block while locked, mode 2 only counts.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (slip_o) slips++;
            if (block_v_o) begin
                blk_seen++;
                if (mon_mode == 0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL blk_extra actual=%h required=no block", block_o);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("blk_data", block_o, mon_e.blk);
                        check("blk_lock", 66'(block_lock_o), 66'(mon_e.lock));
                    end
                end else if (mon_mode == 1 && block_lock_o) begin
                    check("blk_const", block_o, CONST_BLK);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    task automatic push_block(input logic [65:0] b);
        for (int i = 0; i < 66; i++) bitq.push_back(b[i]);
    endtask

    task automatic drive_beat();
        logic [63:0] w;
        for (int i = 0; i < 64; i++) w[i] = bitq.pop_front();
        data_i    = w;
        data_v_i  = 1'b1;
        bits_sent += 64;
        while (pend_q.size() > 0 && bits_sent >= 66 * (blocks_moved + 1)) begin
            exp_q.push_back(pend_q.pop_front());
            blocks_moved++;
        end
    endtask

    task automatic do_reset(input bit mid);
        @(negedge clk);
        reset    = 1'b1;
        data_v_i = mid;
        data_i   = {$urandom, $urandom};
        @(negedge clk);
        data_v_i = 1'b0;
        if (mid) begin
            check_int("rst_block_v", int'(block_v_o), 0);
            check("rst_block", block_o, '0);
            check_int("rst_lock", int'(block_lock_o), 0);
            check_int("rst_slip", int'(slip_o), 0);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        pend_q.delete();
        bitq.delete();
        bits_sent    = 0;
        blocks_moved = 0;
        blk_seen     = 0;
        slips        = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic run_aligned(input int nbeats, input bit tgl, input int lo1, input int hi1,
                               input int lo2, input int hi2, input int drop_at);
        int          nblk;
        logic [1:0]  hdr;
        exp_t        e;
        nblk = (nbeats * 64) / 66 + 2;
        for (int k = 0; k < nblk; k++) begin
            if ((k >= lo1 && k <= hi1) || (k >= lo2 && k <= hi2)) hdr = 2'b00;
            else hdr = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
            e.blk  = {$urandom, $urandom, hdr};
            e.lock = (k >= 63) && !(drop_at >= 0 && k >= drop_at);
            push_block(e.blk);
            pend_q.push_back(e);
        end
        mon_mode = 0;
        for (int b = 0; b < nbeats; b++) begin
            @(negedge clk);
            drive_beat();
            if (tgl) begin
                @(negedge clk);
                data_v_i = 1'b0;
            end
        end
        @(negedge clk);
        data_v_i = 1'b0;
        repeat (4) @(negedge clk);
        check_int("blk_count", blk_seen, (nbeats * 64) / 66);
        check_int("exp_drained", exp_q.size(), 0);
    endtask

    task automatic run_slip();
        int seen_lock = 0;
        int lock_beats = 0;
        int slips_at_lock = -1;
        int bad_left = 0;
        int dropped = 0;
        int beats = 0;
        mon_mode = 1;
        for (int i = 0; i < 3; i++) bitq.push_back(1'b1);
        while (beats < 600 && dropped == 0) begin
            @(negedge clk);
            if (block_lock_o && seen_lock == 0) begin
                seen_lock     = 1;
                slips_at_lock = slips;
            end
            if (seen_lock == 1 && !block_lock_o) begin
                dropped  = 1;
                data_v_i = 1'b0;
            end else begin
                if (seen_lock == 1) lock_beats++;
                if (lock_beats == 20) bad_left = 32;
                while (bitq.size() < 64) begin
                    if (bad_left > 0) begin
                        mon_mode = 2;
                        push_block(BAD_BLK);
                        bad_left--;
                    end else begin
                        push_block(CONST_BLK);
                    end
                end
                drive_beat();
                beats++;
            end
        end
        data_v_i = 1'b0;
        repeat (4) @(negedge clk);
        check_int("slip_before_lock", slips_at_lock, 3);
        check_int("slip_lock_gained", seen_lock, 1);
        check_int("slip_lock_dropped", dropped, 1);
        check_int("slip_total", slips, 4);
        check_int("slip_lock_after", int'(block_lock_o), 0);
`ifdef PCS_RX_LOCK_STATS_EN
        check_int("stat_slip_cnt", int'(slip_cnt_o), 4);
        check_int("stat_lock_loss", int'(lock_loss_cnt_o), 1);
`endif
    endtask

    initial begin
        do_reset(1'b0);
        check_int("reset_lock", int'(block_lock_o), 0);
        check_int("reset_block_v", int'(block_v_o), 0);

        run_aligned(80, 1'b0, -1, -1, -1, -1, -1);
        check_int("aligned_slips", slips, 0);
        check_int("aligned_locked", int'(block_lock_o), 1);

        do_reset(1'b1);
        run_aligned(80, 1'b0, -1, -1, -1, -1, -1);
        check_int("relock_slips", slips, 0);

        do_reset(1'b0);
        run_aligned(161, 1'b0, 70, 84, 140, 155, 155);
        check_int("bad_hdr_slips", slips, 1);
        check_int("bad_hdr_lock", int'(block_lock_o), 0);

        do_reset(1'b0);
        run_aligned(80, 1'b1, -1, -1, -1, -1, -1);
        check_int("toggle_slips", slips, 0);
        check_int("toggle_locked", int'(block_lock_o), 1);

        do_reset(1'b0);
        run_slip();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
